// File: rtl/dmem_arb_pkg.sv
// Shared types for the two-requester data-memory arbiter: FSM states and requester ids.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic REQ_ID0 = 1'b0;
    localparam logic REQ_ID1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant, priority passes away from each winner.
module rr_arbiter2
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // prio_q holds the id of the requester that wins a tie
    logic prio_q;
    logic prio_d;

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (prio_q == REQ_ID0) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_comb begin
        prio_d = prio_q;
        if (advance && (gnt != 2'b00)) begin
            prio_d = gnt[0] ? REQ_ID1 : REQ_ID0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_q <= REQ_ID0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between two requesters, one transaction
// in flight at a time (IDLE -> ACCESS -> RESP).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r0_gnt,
    output logic              r1_gnt,
    output logic              r0_rvalid,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    output logic [DATA_W-1:0] r1_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_read_data
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              id_q, id_d;
    logic [DATA_W-1:0] resp_q, resp_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic [1:0]        arb_req;
    logic [1:0]        arb_gnt;
    logic              in_idle;
    logic              addr_lsb_unused;

    // Byte-offset bits are dropped when the address is latched.
    assign addr_lsb_unused = ^{r0_addr[1:0], r1_addr[1:0]};

    // Requests are only visible to the arbiter in IDLE and outside reset,
    // so a grant is never shown for a transaction that will not start.
    assign in_idle = (state_q == IDLE);
    assign arb_req = {r1_req, r0_req} & {2{in_idle && rst_n}};

    rr_arbiter2 u_rr_arbiter2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (arb_req),
        .advance (in_idle),
        .gnt     (arb_gnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = (arb_gnt != 2'b00) ? ACCESS : IDLE;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        r0_gnt         = arb_gnt[0];
        r1_gnt         = arb_gnt[1];
        r0_rvalid      = 1'b0;
        r1_rvalid      = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        unique case (state_q)
            ACCESS: begin
                mem_address    = addr_q;
                mem_write_data = wdata_q;
                mem_read       = !we_q;
                mem_write      = we_q && rst_n;
            end
            RESP: begin
                r0_rvalid = (id_q == REQ_ID0);
                r1_rvalid = (id_q == REQ_ID1);
            end
            default: ;
        endcase
    end

    // Payload latch on grant; response captured at the ACCESS->RESP edge
    // and copied into the owning requester's rdata register.
    always_comb begin
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        id_d     = id_q;
        resp_d   = resp_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        if (in_idle && (arb_gnt != 2'b00)) begin
            if (arb_gnt[1]) begin
                addr_d  = {r1_addr[ADDR_W-1:2], 2'b00};
                we_d    = r1_we;
                wdata_d = r1_wdata;
                id_d    = REQ_ID1;
            end else begin
                addr_d  = {r0_addr[ADDR_W-1:2], 2'b00};
                we_d    = r0_we;
                wdata_d = r0_wdata;
                id_d    = REQ_ID0;
            end
        end
        if (state_q == ACCESS) begin
            resp_d = we_q ? '0 : mem_read_data;
            if (id_q == REQ_ID0) begin
                rdata0_d = resp_d;
            end else begin
                rdata1_d = resp_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            id_q     <= REQ_ID0;
            resp_q   <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            id_q     <= id_d;
            resp_q   <= resp_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign r0_rdata = rdata0_q;
    assign r1_rdata = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small word-addressed memory model.
module tb_dmem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              r0_req, r0_we, r1_req, r1_we;
    logic [ADDR_W-1:0] r0_addr, r1_addr;
    logic [DATA_W-1:0] r0_wdata, r1_wdata;
    logic              r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
    logic [DATA_W-1:0] r0_rdata, r1_rdata;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_read, mem_write;
    logic [DATA_W-1:0] mem_read_data;

    logic [DATA_W-1:0] mem [0:63];
    logic              pl_en;
    logic [5:0]        pl_idx;
    logic [DATA_W-1:0] pl_val;
    logic              watch_wr;
    int                wr_seen;
    int                n_run;
    int                n_fail;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .r0_req         (r0_req),
        .r0_we          (r0_we),
        .r0_addr        (r0_addr),
        .r0_wdata       (r0_wdata),
        .r1_req         (r1_req),
        .r1_we          (r1_we),
        .r1_addr        (r1_addr),
        .r1_wdata       (r1_wdata),
        .r0_gnt         (r0_gnt),
        .r1_gnt         (r1_gnt),
        .r0_rvalid      (r0_rvalid),
        .r1_rvalid      (r1_rvalid),
        .r0_rdata       (r0_rdata),
        .r1_rdata       (r1_rdata),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_read_data  (mem_read_data)
    );

    assign mem_read_data = mem[mem_address[7:2]];

    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_val;
        else if (mem_write) mem[mem_address[7:2]] <= mem_write_data;
    end

    always @(posedge clk) begin
        if (watch_wr && mem_write) wr_seen <= wr_seen + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic preload(input int idx, input logic [DATA_W-1:0] v);
        pl_en  = 1'b1;
        pl_idx = idx[5:0];
        pl_val = v;
        step();
        pl_en  = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_r0_gnt"},    r0_gnt,         0);
        check({tag, "_r1_gnt"},    r1_gnt,         0);
        check({tag, "_r0_rvalid"}, r0_rvalid,      0);
        check({tag, "_r1_rvalid"}, r1_rvalid,      0);
        check({tag, "_mem_read"},  mem_read,       0);
        check({tag, "_mem_write"}, mem_write,      0);
        check({tag, "_mem_addr"},  mem_address,    0);
        check({tag, "_mem_wdata"}, mem_write_data, 0);
    endtask

    initial begin
        n_run = 0; n_fail = 0; wr_seen = 0; watch_wr = 1'b0;
        pl_en = 1'b0; pl_idx = '0; pl_val = '0;
        rst_n = 1'b0;
        r0_req = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
        r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;

        // Reset and memory preload
        step();
        preload(4,  32'hDEADBEEF);
        preload(8,  32'h0000_0000);
        preload(12, 32'h5555_5555);
        settle();
        check_quiet("rst_low");
        step();
        rst_n = 1'b1;
        settle();
        check_quiet("rst_rel");
        check("rst_r0_rdata", r0_rdata, 0);
        check("rst_r1_rdata", r1_rdata, 0);

        // Single read by r0
        step();
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h10;
        settle();
        check("rd_c0_r0_gnt", r0_gnt, 1);
        check("rd_c0_r1_gnt", r1_gnt, 0);
        check("rd_c0_mem_read", mem_read, 0);
        step();
        r0_req = 1'b0;
        settle();
        check("rd_c1_mem_read", mem_read, 1);
        check("rd_c1_mem_write", mem_write, 0);
        check("rd_c1_mem_addr", mem_address, 32'h10);
        check("rd_c1_r0_gnt", r0_gnt, 0);
        step();
        settle();
        check("rd_c2_r0_rvalid", r0_rvalid, 1);
        check("rd_c2_r0_rdata", r0_rdata, 32'hDEADBEEF);
        check("rd_c2_r1_rvalid", r1_rvalid, 0);
        check("rd_c2_mem_read", mem_read, 0);
        step();
        settle();
        check("rd_c3_r0_rvalid", r0_rvalid, 0);

        // r1 write then read back
        step();
        r1_req = 1'b1; r1_we = 1'b1; r1_addr = 32'h20; r1_wdata = 32'h12345678;
        settle();
        check("wr_c0_r1_gnt", r1_gnt, 1);
        check("wr_c0_r0_gnt", r0_gnt, 0);
        step();
        r1_req = 1'b0;
        settle();
        check("wr_c1_mem_write", mem_write, 1);
        check("wr_c1_mem_read", mem_read, 0);
        check("wr_c1_mem_addr", mem_address, 32'h20);
        check("wr_c1_mem_wdata", mem_write_data, 32'h12345678);
        step();
        settle();
        check("wr_c2_mem_write", mem_write, 0);
        check("wr_c2_r1_rvalid", r1_rvalid, 1);
        check("wr_c2_r1_rdata", r1_rdata, 0);
        check("wr_mem8", mem[8], 32'h12345678);
        step();
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 32'h20;
        settle();
        check("rb_c0_r1_gnt", r1_gnt, 1);
        step();
        r1_req = 1'b0;
        settle();
        check("rb_c1_mem_read", mem_read, 1);
        step();
        settle();
        check("rb_c2_r1_rvalid", r1_rvalid, 1);
        check("rb_c2_r1_rdata", r1_rdata, 32'h12345678);
        check("rb_c2_r0_rvalid", r0_rvalid, 0);

        // Misaligned read address
        step();
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h13;
        settle();
        check("mis_c0_r0_gnt", r0_gnt, 1);
        step();
        r0_req = 1'b0;
        settle();
        check("mis_c1_mem_addr", mem_address, 32'h10);
        step();
        settle();
        check("mis_c2_r0_rdata", r0_rdata, 32'hDEADBEEF);

        // Contention from reset
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h10;
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 32'h20;
        for (int c = 0; c < 12; c++) begin
            settle();
            check($sformatf("rr_c%0d_r0_gnt", c), r0_gnt, (c == 0 || c == 6) ? 1 : 0);
            check($sformatf("rr_c%0d_r1_gnt", c), r1_gnt, (c == 3 || c == 9) ? 1 : 0);
            check($sformatf("rr_c%0d_r0_rvalid", c), r0_rvalid, (c == 2 || c == 8) ? 1 : 0);
            check($sformatf("rr_c%0d_r1_rvalid", c), r1_rvalid, (c == 5 || c == 11) ? 1 : 0);
            step();
        end

        // Late request: r1 arrives during r0's ACCESS
        r1_req = 1'b0;
        settle();
        check("late_c0_r0_gnt", r0_gnt, 1);
        step();
        r0_req = 1'b0;
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 32'h20;
        settle();
        check("late_c1_r1_gnt", r1_gnt, 0);
        check("late_c1_mem_addr", mem_address, 32'h10);
        step();
        settle();
        check("late_c2_r1_gnt", r1_gnt, 0);
        check("late_c2_r0_rvalid", r0_rvalid, 1);
        step();
        settle();
        check("late_c3_r1_gnt", r1_gnt, 1);
        check("late_c3_r0_gnt", r0_gnt, 0);
        step();
        r1_req = 1'b0;
        settle();
        check("late_c4_mem_addr", mem_address, 32'h20);
        step();
        settle();
        check("late_c5_r1_rvalid", r1_rvalid, 1);
        check("late_c5_r1_rdata", r1_rdata, 32'h12345678);

        // Reset during ACCESS of a write
        step();
        watch_wr = 1'b1;
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 32'h30; r0_wdata = 32'hAA;
        settle();
        check("abort_c0_r0_gnt", r0_gnt, 1);
        step();
        r0_req = 1'b0; r0_we = 1'b0;
        rst_n = 1'b0;
        settle();
        check("abort_c1_mem_write", mem_write, 0);
        step();
        settle();
        check_quiet("abort_c2");
        step();
        rst_n = 1'b1;
        r0_req = 1'b1; r0_addr = 32'h10;
        r1_req = 1'b1; r1_addr = 32'h20;
        settle();
        check("abort_c3_r0_gnt", r0_gnt, 1);
        check("abort_c3_r1_gnt", r1_gnt, 0);
        check("abort_c3_r0_rvalid", r0_rvalid, 0);
        check("abort_mem12", mem[12], 32'h5555_5555);
        step();
        r0_req = 1'b0; r1_req = 1'b0;
        watch_wr = 1'b0;
        settle();
        check("abort_wr_seen", wr_seen, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, requester/memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, data word width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous reset, active-low.
REQ-005 SHALL have ports r0_req / r1_req  input  1  access request from requester 0 / 1.
REQ-006 SHALL have ports r0_we / r1_we  input  1  1 = write, 0 = read.
REQ-007 SHALL have ports r0_addr / r1_addr  input  ADDR_W  byte address, word-aligned.
REQ-008 SHALL have ports r0_wdata / r1_wdata  input  DATA_W  write data.
REQ-009 SHALL have ports r0_gnt / r1_gnt  output  1  request accepted this cycle.
REQ-010 SHALL have ports r0_rvalid / r1_rvalid  output  1  one-cycle completion pulse (read and write).
REQ-011 SHALL have ports r0_rdata / r1_rdata  output  DATA_W  read result, valid with rvalid.
REQ-012 SHALL have port mem_address  output  ADDR_W  to data memory.
REQ-013 SHALL have port mem_write_data  output  DATA_W  to data memory.
REQ-014 SHALL have ports mem_read / mem_write  output  1  memory control strobes.
REQ-015 SHALL have port mem_read_data  input  DATA_W  combinational read data from memory.

Function
REQ-016 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; one transaction in flight; throughput one per 3 cycles.
REQ-017 IDLE: if any req high, SHALL assert exactly one gnt combinationally that cycle, latch addr/we/wdata/id at the edge, go to ACCESS; no req -> stay IDLE.
REQ-018 gnt SHALL be asserted only in IDLE; requesters hold req and payload stable until gnt seen.
REQ-019 Arbitration SHALL be round-robin: single req wins; both high -> priority holder wins; after a grant priority passes to the other requester.
REQ-020 ACCESS: SHALL drive mem_address = latched addr with bits [1:0] forced 0, mem_write_data = latched wdata, mem_read = !we, mem_write = we; all four strobes/data otherwise mem_read = mem_write = 0, bus values 0.
REQ-021 ACCESS read: SHALL capture mem_read_data into response register at the ACCESS->RESP edge.
REQ-022 ACCESS write: memory write occurs at the ACCESS->RESP edge; response register SHALL be loaded with 0.
REQ-023 RESP: SHALL pulse rvalid for the latched id only, one cycle; rdata of that requester = response register; other requester's rvalid = 0.
REQ-024 r0_rdata/r1_rdata SHALL hold last value outside rvalid; no meaning required.
REQ-025 A req arriving during ACCESS/RESP SHALL wait; it is granted in the next IDLE cycle.
REQ-026 mem_write SHALL be gated combinationally by rst_n, so no memory write occurs in any cycle with rst_n low.

Reset
REQ-027 On rising edge with rst_n low: state = IDLE, priority = requester 0, latched payload and response register = 0.
REQ-028 Reset mid-transaction SHALL abort it: no rvalid issued, write suppressed if in ACCESS.
REQ-029 Post-reset outputs: all gnt, rvalid, mem_read, mem_write = 0; mem_address, mem_write_data, rdata = 0.

Structure
REQ-030 Shared package dmem_arb_pkg SHALL hold FSM state enum (IDLE, ACCESS, RESP) and requester-id constants REQ_ID0, REQ_ID1.
REQ-031 Arbitration SHALL live in sub-module rr_arbiter2 (2 req in, 2 one-hot gnt out, priority register, advance input).

Verification
REQ-032 Single read: preload mem[4]=0xDEADBEEF; r0 read addr 0x10 -> r0_gnt cycle 0, mem_read cycle 1, r0_rvalid cycle 2 with rdata 0xDEADBEEF.
REQ-033 Write then read: r1 write 0x20 data 0x12345678, then r1 read 0x20 -> mem_write exactly one cycle, read returns 0x12345678.
REQ-034 Contention: r0 and r1 both request from reset, held -> grants alternate r0, r1, r0, r1, each 3 cycles apart.
REQ-035 Misaligned: r0 read addr 0x13 -> mem_address = 0x10.
REQ-036 Reset in ACCESS of a write to 0x30 data 0xAA -> mem_write never high, mem[12] unchanged, no rvalid, next req granted to r0.
REQ-037 Late request: r1 raises req during r0's ACCESS -> r1_gnt in first IDLE cycle after r0's RESP.
